// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared types for the SPI byte-stream controller.
// Holds the controller FSM encoding and the byte width.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } spi_ctrl_state_t;

endpackage

// File: rtl/spi_xfer_ctrl_sync_fifo.sv
// Synchronous first-word-fallthrough FIFO with flush.
// Head reads as zero while the FIFO is empty.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && !full && !flush;
        pop_ok   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Byte-stream controller feeding a Mode0 SPI byte engine.
// Owns chip select with setup delay, TX/RX buffering and overflow status.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int CS_SETUP = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_push,
    input  logic [SPI_BYTE_W-1:0] tx_byte,
    input  logic                  rx_pop,
    output logic [SPI_BYTE_W-1:0] rx_byte,
    input  logic                  cs_wr,
    input  logic                  cs_val,
    input  logic                  flush,
    input  logic                  clr_ovf,
    output logic                  tx_full,
    output logic                  rx_empty,
    output logic                  rx_ovf,
    output logic                  busy,
    output logic                  cs_n,
    output logic [SPI_BYTE_W-1:0] spi_tx_data,
    output logic                  spi_tx_start,
    input  logic [SPI_BYTE_W-1:0] spi_rx_data,
    input  logic                  spi_tx_ready
);

    localparam int SW = $clog2(CS_SETUP + 1);

    spi_ctrl_state_t state_q, state_d;
    logic          cs_n_q, cs_n_d;
    logic          pend_q, pend_d;
    logic          pend_val_q, pend_val_d;
    logic [SW-1:0] setup_q, setup_d;
    logic          ovf_q, ovf_d;
    logic          drop_q, drop_d;
    logic          cs_apply;
    logic          tx_pop;
    logic          tx_empty;
    logic          capture;
    logic          rx_push;
    logic          rx_full;

    sync_fifo #(.W(SPI_BYTE_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (flush),
        .din   (tx_byte),
        .dout  (spi_tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(.W(SPI_BYTE_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (flush),
        .din   (spi_rx_data),
        .dout  (rx_byte),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cs_n_q     <= 1'b1;
            pend_q     <= 1'b0;
            pend_val_q <= 1'b0;
            setup_q    <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_n_q     <= cs_n_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            setup_q    <= setup_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    // A pending deselect waits until the queued bytes have drained.
    always_comb begin
        state_d  = state_q;
        cs_apply = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q && (pend_val_q || tx_empty)) begin
                    cs_apply = 1'b1;
                end else if (!cs_n_q && !tx_empty && spi_tx_ready
                             && setup_q == '0) begin
                    state_d = START;
                end
            end
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (!spi_tx_ready) state_d = WAIT_DONE;
            WAIT_DONE: if (spi_tx_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_pop       = (state_q == START);
        spi_tx_start = (state_q == START);
        capture      = (state_q == WAIT_DONE) && spi_tx_ready;
        rx_push      = capture && !drop_q;
        busy         = (state_q != IDLE) || !tx_empty || pend_q;
        cs_n         = cs_n_q;
        rx_ovf       = ovf_q;
    end

    always_comb begin
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        cs_n_d     = cs_n_q;
        setup_d    = setup_q;
        ovf_d      = ovf_q;
        drop_d     = drop_q;
        if (cs_apply) pend_d = 1'b0;
        if (cs_wr) begin
            pend_d     = 1'b1;
            pend_val_d = cs_val;
        end
        if (setup_q != '0) setup_d = setup_q - SW'(1);
        // Counter is checked before the edge, so load one less.
        if (cs_apply) begin
            cs_n_d = !pend_val_q;
            if (pend_val_q) setup_d = SW'(CS_SETUP - 1);
        end
        if (clr_ovf) ovf_d = 1'b0;
        if (rx_push && rx_full && !flush) ovf_d = 1'b1;
        if (flush && state_q != IDLE) drop_d = 1'b1;
        if (capture) drop_d = 1'b0;
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a behavioural loopback byte engine.
// Vector table for the static FIFO/CS behaviour, sequences for transfers.
module tb_spi_xfer_ctrl;

    localparam int CS_SETUP = 2;
    localparam int BIT_CLKS = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_push;
    logic [7:0] tx_byte;
    logic       rx_pop;
    logic [7:0] rx_byte;
    logic       cs_wr;
    logic       cs_val;
    logic       flush;
    logic       clr_ovf;
    logic       tx_full;
    logic       rx_empty;
    logic       rx_ovf;
    logic       busy;
    logic       cs_n;
    logic [7:0] spi_tx_data;
    logic       spi_tx_start;
    logic [7:0] spi_rx_data;
    logic       spi_tx_ready;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    spi_xfer_ctrl #(.TX_DEPTH(4), .RX_DEPTH(4), .CS_SETUP(CS_SETUP)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_push      (tx_push),
        .tx_byte      (tx_byte),
        .rx_pop       (rx_pop),
        .rx_byte      (rx_byte),
        .cs_wr        (cs_wr),
        .cs_val       (cs_val),
        .flush        (flush),
        .clr_ovf      (clr_ovf),
        .tx_full      (tx_full),
        .rx_empty     (rx_empty),
        .rx_ovf       (rx_ovf),
        .busy         (busy),
        .cs_n         (cs_n),
        .spi_tx_data  (spi_tx_data),
        .spi_tx_start (spi_tx_start),
        .spi_rx_data  (spi_rx_data),
        .spi_tx_ready (spi_tx_ready)
    );

    // Engine model: ready drops the cycle after start, byte takes 8 bits
    // of BIT_CLKS each, MISO looped to MOSI so the same byte comes back.
    logic [7:0] eng_sh;
    int         eng_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_tx_ready <= 1'b1;
            spi_rx_data  <= 8'h00;
            eng_sh       <= 8'h00;
            eng_cnt      <= 0;
        end else if (spi_tx_ready) begin
            if (spi_tx_start) begin
                spi_tx_ready <= 1'b0;
                eng_cnt      <= 8 * BIT_CLKS;
                eng_sh       <= spi_tx_data;
            end
        end else if (eng_cnt == 1) begin
            spi_tx_ready <= 1'b1;
            spi_rx_data  <= eng_sh;
            done_cnt     <= done_cnt + 1;
        end else begin
            eng_cnt <= eng_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (!rst && spi_tx_start) pulses <= pulses + 1;
    end

    typedef struct {
        logic        push;
        logic [7:0]  byt;
        logic        cs_wr;
        logic        cs_val;
        logic        flush;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_push = 1'b1;
        tx_byte = b;
        tick();
        tx_push = 1'b0;
    endtask

    task automatic cs_req(input logic v);
        cs_wr  = 1'b1;
        cs_val = v;
        tick();
        cs_wr  = 1'b0;
    endtask

    task automatic pop_rx;
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        chk(name, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int d0;
        int n;
        logic early;

        // {tx_full, rx_empty, busy, cs_n, tx_start, rx_ovf, tx_data}
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, {6'b010100, 8'h00}};
        vecs[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, {6'b011100, 8'h11}};
        vecs[2]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, {6'b011100, 8'h11}};
        vecs[3]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, {6'b011100, 8'h11}};
        vecs[4]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, {6'b111100, 8'h11}};
        vecs[5]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, {6'b111100, 8'h11}};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, {6'b010100, 8'h00}};
        vecs[7]  = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, {6'b010100, 8'h00}};
        vecs[8]  = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, {6'b011100, 8'h77}};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, {6'b010100, 8'h00}};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, {6'b011100, 8'h00}};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, {6'b010100, 8'h00}};

        rst = 1'b1;
        tx_push = 1'b0;
        tx_byte = 8'h00;
        rx_pop = 1'b0;
        cs_wr = 1'b0;
        cs_val = 1'b0;
        flush = 1'b0;
        clr_ovf = 1'b0;
        repeat (3) tick();
        chk("reset_rx_byte", {24'b0, rx_byte}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            tx_push = vecs[i].push;
            tx_byte = vecs[i].byt;
            cs_wr   = vecs[i].cs_wr;
            cs_val  = vecs[i].cs_val;
            flush   = vecs[i].flush;
            tick();
            tx_push = 1'b0;
            cs_wr   = 1'b0;
            flush   = 1'b0;
            chk($sformatf("vec%0d", i),
                {18'b0, tx_full, rx_empty, busy, cs_n, spi_tx_start,
                 rx_ovf, spi_tx_data}, {18'b0, vecs[i].exp});
        end

        // Select plus first byte: setup delay then a single pulse.
        p0 = pulses;
        cs_wr = 1'b1;
        cs_val = 1'b1;
        tx_push = 1'b1;
        tx_byte = 8'hA5;
        tick();
        cs_wr = 1'b0;
        tx_push = 1'b0;
        n = 0;
        while (cs_n && n < 10) begin
            tick();
            n++;
        end
        chk("cs_low", {31'b0, cs_n}, 32'd0);
        n = 0;
        while (!spi_tx_start && n < 20) begin
            tick();
            n++;
        end
        chk("setup_cycles", n, CS_SETUP);
        tick();
        chk("start_one_cycle", {31'b0, spi_tx_start}, 32'd0);
        wait_idle(300, "a5_idle");
        chk("a5_pulses", pulses - p0, 1);
        chk("a5_rx_empty", {31'b0, rx_empty}, 32'd0);
        chk("a5_rx_byte", {24'b0, rx_byte}, 32'hA5);
        pop_rx();
        chk("a5_popped", {31'b0, rx_empty}, 32'd1);

        // Queue while deselected so the FIFO can fill, then release.
        cs_req(1'b0);
        tick();
        chk("desel", {31'b0, cs_n}, 32'd1);
        for (int i = 1; i <= 5; i++) begin
            push_byte(8'(i));
            if (i == 4) chk("tx_full_4", {31'b0, tx_full}, 32'd1);
        end
        chk("tx_full_5", {31'b0, tx_full}, 32'd1);
        chk("tx_head_5", {24'b0, spi_tx_data}, 32'h01);
        p0 = pulses;
        cs_req(1'b1);
        wait_idle(1000, "burst_idle");
        chk("burst_pulses", pulses - p0, 4);
        chk("burst_head", {24'b0, rx_byte}, 32'h01);

        // RX full: next byte is dropped and flagged.
        p0 = pulses;
        push_byte(8'h55);
        wait_idle(300, "ovf_idle");
        chk("ovf_pulses", pulses - p0, 1);
        chk("ovf_set", {31'b0, rx_ovf}, 32'd1);
        chk("ovf_head", {24'b0, rx_byte}, 32'h01);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr", {31'b0, rx_ovf}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("burst_rx%0d", i), {24'b0, rx_byte}, i);
            pop_rx();
        end
        chk("burst_drained", {31'b0, rx_empty}, 32'd1);

        // Deselect requested right behind three bytes waits for drain.
        p0 = pulses;
        d0 = done_cnt;
        push_byte(8'hAA);
        push_byte(8'hBB);
        push_byte(8'hCC);
        cs_req(1'b0);
        early = 1'b0;
        n = 0;
        while (busy && n < 1000) begin
            if (cs_n && (done_cnt - d0) < 3) early = 1'b1;
            tick();
            n++;
        end
        chk("drain_idle", {31'b0, busy}, 32'd0);
        chk("drain_cs_early", {31'b0, early}, 32'd0);
        chk("drain_cs_high", {31'b0, cs_n}, 32'd1);
        chk("drain_pulses", pulses - p0, 3);
        chk("drain_rx0", {24'b0, rx_byte}, 32'hAA);
        pop_rx();
        chk("drain_rx1", {24'b0, rx_byte}, 32'hBB);
        pop_rx();
        chk("drain_rx2", {24'b0, rx_byte}, 32'hCC);
        pop_rx();

        // Byte held while deselected, sent once selected.
        p0 = pulses;
        push_byte(8'h3C);
        repeat (50) tick();
        chk("held_pulses", pulses - p0, 0);
        chk("held_busy", {31'b0, busy}, 32'd1);
        chk("held_head", {24'b0, spi_tx_data}, 32'h3C);
        cs_req(1'b1);
        wait_idle(300, "held_idle");
        chk("held_sent", pulses - p0, 1);
        chk("held_rx", {24'b0, rx_byte}, 32'h3C);
        pop_rx();

        // Reset in the middle of a transfer.
        push_byte(8'h5A);
        n = 0;
        while (spi_tx_ready && n < 20) begin
            tick();
            n++;
        end
        chk("rst_engine_busy", {31'b0, spi_tx_ready}, 32'd0);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("rst_cs_n", {31'b0, cs_n}, 32'd1);
        chk("rst_rx_empty", {31'b0, rx_empty}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_stays_idle", {30'b0, busy, spi_tx_start}, 32'd0);

        // Flush mid-byte: wire finishes, RX byte discarded.
        cs_req(1'b1);
        p0 = pulses;
        push_byte(8'h77);
        n = 0;
        while (spi_tx_ready && n < 20) begin
            tick();
            n++;
        end
        chk("flush_engine_busy", {31'b0, spi_tx_ready}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_still_busy", {31'b0, busy}, 32'd1);
        wait_idle(300, "flush_idle");
        chk("flush_pulses", pulses - p0, 1);
        chk("flush_rx_empty", {31'b0, rx_empty}, 32'd1);
        chk("flush_ovf", {31'b0, rx_ovf}, 32'd0);
        chk("flush_cs_n", {31'b0, cs_n}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
